// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer in front of a big-endian word memory.
// Sub-word stores are done as read-modify-write because the memory always
// writes a full word.
// Ports: CLK, Reset (async, active-low); request: start, we, size, sign_ext,
// addr, wdata; status: busy, done, fault, rdata; memory side: mem_addr,
// mem_wdata, mem_rw (1 = write), mem_rdata (combinational read data).
module mem_access_unit #(
    parameter int MEM_BYTES = 64
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        start,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rw,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [31:0] LIMIT = 32'(MEM_BYTES);

    state_t state, state_nx;

    logic [31:0] base;
    logic        bad;
    logic [1:0]  q_off;
    logic [1:0]  q_size;
    logic        q_sx;
    logic        q_we;
    logic [31:0] q_wd;

    logic [4:0]  sh;
    logic [31:0] mask;
    logic [31:0] field;
    logic [31:0] ext;
    logic [31:0] merged;

    assign base = {addr[31:2], 2'b00};

    always_comb begin
        bad = 1'b0;
        unique case (1'b1)
            (size == 2'b11): bad = 1'b1;
            (size == 2'b01): bad = addr[0];
            (size == 2'b10): bad = |addr[1:0];
            default:         bad = 1'b0;
        endcase
        if (base >= LIMIT)
            bad = 1'b1;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (bad)
                        state_nx = S_FAULT;
                    else if (we && size == 2'b10)
                        state_nx = S_WR;
                    else
                        state_nx = S_RD;
                end
            end
            S_RD:    state_nx = q_we ? S_WR : S_DONE;
            S_WR:    state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            S_FAULT: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == S_RD) || (state == S_WR);
        done   = (state == S_DONE) || (state == S_FAULT);
        fault  = (state == S_FAULT);
        mem_rw = (state == S_WR);
    end

    // Lane of the addressed field: byte k sits at bit 8*(3-k),
    // half at offset 0 sits at bit 16, half at offset 2 at bit 0.
    always_comb begin
        sh   = 5'd0;
        mask = 32'hFFFF_FFFF;
        unique case (q_size)
            2'b00: begin
                sh   = {~q_off, 3'b000};
                mask = 32'h0000_00FF << sh;
            end
            2'b01: begin
                sh   = {~q_off[1], 4'b0000};
                mask = 32'h0000_FFFF << sh;
            end
            default: begin
                sh   = 5'd0;
                mask = 32'hFFFF_FFFF;
            end
        endcase
        field  = (mem_rdata & mask) >> sh;
        merged = (mem_rdata & ~mask) | ((q_wd << sh) & mask);
        unique case (q_size)
            2'b00:   ext = {{24{q_sx & field[7]}}, field[7:0]};
            2'b01:   ext = {{16{q_sx & field[15]}}, field[15:0]};
            default: ext = field;
        endcase
    end

    // mem_addr/mem_wdata only move in IDLE and RD, never while writing.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            q_off     <= '0;
            q_size    <= '0;
            q_sx      <= 1'b0;
            q_we      <= 1'b0;
            q_wd      <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start && !bad) begin
                        mem_addr <= base;
                        q_off    <= addr[1:0];
                        q_size   <= size;
                        q_sx     <= sign_ext;
                        q_we     <= we;
                        q_wd     <= wdata;
                        if (we && size == 2'b10)
                            mem_wdata <= wdata;
                    end
                end
                S_RD: begin
                    if (q_we)
                        mem_wdata <= merged;
                    else
                        rdata <= ext;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed bench for mem_access_unit.
// A byte-array reference model predicts memory, rdata, latency and faults.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        start = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic [31:0] mem_rdata;

    logic [31:0] mem [16];
    logic [7:0]  ref_b [64];
    logic [31:0] exp_rdata = '0;
    int          checks = 0;
    int          failures = 0;
    int          rw_cnt = 0;
    int          done_cnt = 0;

    mem_access_unit #(.MEM_BYTES(64)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .start     (start),
        .we        (we),
        .size      (size),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rw    (mem_rw),
        .mem_rdata (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[5:2]];

    always #5 CLK = ~CLK;

    function automatic logic [31:0] ref_word(input int i);
        return {ref_b[4*i], ref_b[4*i+1], ref_b[4*i+2], ref_b[4*i+3]};
    endfunction

    function automatic bit is_fault(input logic [1:0] sz,
                                    input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
               (sz == 2'd2 && a[1:0] != 2'd0) || (a >= 32'd64);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz,
                                             input logic sx,
                                             input int a);
        int v;
        if (sz == 2'd0) begin
            v = int'(ref_b[a]);
            if (sx && v > 127)
                v = v - 256;
        end else if (sz == 2'd1) begin
            v = int'(ref_b[a]) * 256 + int'(ref_b[a+1]);
            if (sx && v > 32767)
                v = v - 65536;
        end else begin
            return {ref_b[a], ref_b[a+1], ref_b[a+2], ref_b[a+3]};
        end
        return 32'(v);
    endfunction

    task automatic ref_store(input logic [1:0] sz, input int a,
                             input logic [31:0] wd);
        if (sz == 2'd0) begin
            ref_b[a] = wd[7:0];
        end else if (sz == 2'd1) begin
            ref_b[a]   = wd[15:8];
            ref_b[a+1] = wd[7:0];
        end else begin
            ref_b[a]   = wd[31:24];
            ref_b[a+1] = wd[23:16];
            ref_b[a+2] = wd[15:8];
            ref_b[a+3] = wd[7:0];
        end
    endtask

    // One clock edge; the memory commits what it saw while mem_rw was high.
    task automatic tick();
        logic        p;
        logic [31:0] a;
        logic [31:0] d;
        p = mem_rw;
        a = mem_addr;
        d = mem_wdata;
        @(posedge CLK);
        #1;
        if (p) begin
            mem[a[5:2]] = d;
            rw_cnt++;
            checks++;
            if (mem_addr !== a || mem_wdata !== d) begin
                failures++;
                $display("FAIL wr_stable: addr %h data %h want %h %h",
                         mem_addr, mem_wdata, a, d);
            end
        end
        if (done)
            done_cnt++;
    endtask

    task automatic check_mem(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (mem[i] !== ref_word(i))
                bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s mem: %0d words differ, word2 %h want %h",
                     tag, bad, mem[2], ref_word(2));
        end
    endtask

    task automatic do_op(input logic w, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a,
                         input logic [31:0] wd, input string tag);
        bit          f;
        int          lat;
        int          n;
        int          rw0;
        logic [31:0] wd0;
        f   = is_fault(sz, a);
        lat = f ? 1 : ((!w || sz == 2'd2) ? 2 : 3);
        wd0 = mem_wdata;
        rw0 = rw_cnt;
        we = w;
        size = sz;
        sign_ext = sx;
        addr = a;
        wdata = wd;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        if (!f) begin
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL %s busy: got %b want 1", tag, busy);
            end
        end
        while (!done && n < 8) begin
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1 || n != lat) begin
            failures++;
            $display("FAIL %s latency: got %0d (done=%b) want %0d",
                     tag, n, done, lat);
        end
        checks++;
        if (fault !== f) begin
            failures++;
            $display("FAIL %s fault: got %b want %b", tag, fault, f);
        end
        if (!f) begin
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL %s busy_done: got %b want 0", tag, busy);
            end
            if (w)
                ref_store(sz, int'(a), wd);
            else
                exp_rdata = ref_load(sz, sx, int'(a));
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL %s done_drop: got %b want 0", tag, done);
        end
        checks++;
        if (rw_cnt - rw0 != ((!f && w) ? 1 : 0)) begin
            failures++;
            $display("FAIL %s rw_cycles: got %0d want %0d",
                     tag, rw_cnt - rw0, (!f && w) ? 1 : 0);
        end
        checks++;
        if (rdata !== exp_rdata) begin
            failures++;
            $display("FAIL %s rdata: got %h want %h", tag, rdata, exp_rdata);
        end
        if (f || !w) begin
            checks++;
            if (mem_wdata !== wd0) begin
                failures++;
                $display("FAIL %s wdata_held: got %h want %h",
                         tag, mem_wdata, wd0);
            end
        end
        check_mem(tag);
    endtask

    task automatic check_idle_zero(input string tag);
        logic [98:0] v;
        v = {busy, done, fault, mem_rw, rdata, mem_addr, mem_wdata};
        checks++;
        if (v !== '0) begin
            failures++;
            $display("FAIL %s reset_vals: got %h want 0", tag, v);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        tick();
        tick();
        check_idle_zero("reset");
        Reset = 1'b1;
        tick();
        check_idle_zero("after_reset");
    endtask

    task automatic test_word();
        do_op(1'b1, 2'd2, 1'b0, 32'd8, 32'h1122_3344, "word_st");
        checks++;
        if (mem[2] !== 32'h1122_3344) begin
            failures++;
            $display("FAIL word_st: got %h want 11223344", mem[2]);
        end
        do_op(1'b0, 2'd2, 1'b0, 32'd8, 32'h0, "word_ld");
        checks++;
        if (rdata !== 32'h1122_3344) begin
            failures++;
            $display("FAIL word_ld: got %h want 11223344", rdata);
        end
    endtask

    task automatic test_byte();
        do_op(1'b1, 2'd0, 1'b0, 32'd9, 32'h0000_00AB, "byte_st");
        checks++;
        if (mem[2] !== 32'h11AB_3344) begin
            failures++;
            $display("FAIL byte_st: got %h want 11ab3344", mem[2]);
        end
        do_op(1'b0, 2'd0, 1'b1, 32'd9, 32'h0, "byte_ld_s");
        checks++;
        if (rdata !== 32'hFFFF_FFAB) begin
            failures++;
            $display("FAIL byte_ld_s: got %h want ffffffab", rdata);
        end
        do_op(1'b0, 2'd0, 1'b0, 32'd9, 32'h0, "byte_ld_z");
        checks++;
        if (rdata !== 32'h0000_00AB) begin
            failures++;
            $display("FAIL byte_ld_z: got %h want 000000ab", rdata);
        end
    endtask

    task automatic test_half();
        do_op(1'b1, 2'd1, 1'b0, 32'd10, 32'h0000_8001, "half_st");
        checks++;
        if (mem[2] !== 32'h11AB_8001) begin
            failures++;
            $display("FAIL half_st: got %h want 11ab8001", mem[2]);
        end
        do_op(1'b0, 2'd1, 1'b1, 32'd10, 32'h0, "half_ld");
        checks++;
        if (rdata !== 32'hFFFF_8001) begin
            failures++;
            $display("FAIL half_ld: got %h want ffff8001", rdata);
        end
    endtask

    task automatic test_faults();
        do_op(1'b0, 2'd2, 1'b0, 32'd6, 32'h0, "flt_word_ld");
        do_op(1'b1, 2'd1, 1'b0, 32'd3, 32'hBEEF, "flt_half_st");
        do_op(1'b1, 2'd3, 1'b0, 32'd4, 32'h1234_5678, "flt_size");
        do_op(1'b1, 2'd2, 1'b0, 32'd64, 32'hDEAD_BEEF, "flt_range");
    endtask

    task automatic test_reset_mid();
        int rw0;
        rw0 = rw_cnt;
        we = 1'b1;
        size = 2'd0;
        sign_ext = 1'b0;
        addr = 32'd13;
        wdata = 32'h5A;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid busy: got %b want 1", busy);
        end
        Reset = 1'b0;
        #1;
        check_idle_zero("rst_mid");
        tick();
        tick();
        Reset = 1'b1;
        done_cnt = 0;
        tick();
        tick();
        tick();
        exp_rdata = '0;
        checks++;
        if (rw_cnt != rw0 || done_cnt != 0) begin
            failures++;
            $display("FAIL rst_mid writes: got %0d dones %0d want 0 0",
                     rw_cnt - rw0, done_cnt);
        end
        check_mem("rst_mid");
    endtask

    task automatic test_start_busy();
        we = 1'b1;
        size = 2'd0;
        sign_ext = 1'b0;
        addr = 32'd17;
        wdata = 32'h3C;
        start = 1'b1;
        done_cnt = 0;
        tick();
        tick();
        tick();
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++)
            tick();
        ref_store(2'd0, 17, 32'h3C);
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL start_busy dones: got %0d want 1", done_cnt);
        end
        check_mem("start_busy");
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++)
            do_op(1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 71)),
                  $urandom, "rand");
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom;
            ref_b[4*i]   = mem[i][31:24];
            ref_b[4*i+1] = mem[i][23:16];
            ref_b[4*i+2] = mem[i][15:8];
            ref_b[4*i+3] = mem[i][7:0];
        end
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_faults();
        test_reset_mid();
        test_start_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
